multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
//
// PURPOSE
//  Multi-cycle sequencer for the RV64 subset datapath (R-type, I-type ALU, ld, sd, beq).
//  Steps each instruction through FETCH/DECODE/EXEC/MEM/WB states.
//  Drives per-state datapath controls and a req/ready handshake to instruction and data memory.
//  Sits between the shared-ALU datapath and the memory ports; it replaces the single-cycle decoder.
//
// PARAMETERS
//  OPCODE_W    7    opcode field width
//  TMO_CYC     15   max wait cycles on mem_ready before fault
//  CNT_W       32   retired-instruction counter width
//
// PORTS
//  clk          in   1        system clock; the only clock
//  rst_n        in   1        asynchronous, active-low reset
//  run          in   1        level; enables fetching; sampled only at instruction boundary
//  opcode       in   OPCODE_W IR[6:0]; valid from DECODE onward
//  zero         in   1        ALU zero flag, valid in EXEC
//  mem_ready    in   1        memory completes current access this cycle
//  clear_fault  in   1        pulse; FAULT -> IDLE
//  imem_req     out  1        instruction fetch request
//  mem_read     out  1        data load request
//  mem_write    out  1        data store request
//  ir_write     out  1        load IR from imem read data
//  pc_write     out  1        update PC
//  pc_src       out  1        0: PC+4, 1: branch target
//  alu_src      out  1        0: rs2, 1: immediate
//  alu_op       out  2        00 add, 01 sub/compare, 10 R funct, 11 I funct
//  mem_to_reg   out  1        writeback source = load data
//  reg_write    out  1        register file write enable
//  instr_done   out  1        one-cycle pulse at retirement
//  instr_cnt    out  CNT_W    retired count, wraps to 0
//  fault        out  1        sticky error flag
//  fault_code   out  2        01 illegal opcode, 10 mem timeout, 00 none
//
// BEHAVIOUR
//  - Reset (async): state IDLE; instr_cnt = 0; all outputs 0; wait counter 0.
//  - All controls default to 0 in every state; never X.
//  - IDLE: run=1 -> FETCH.
//  - FETCH: imem_req=1 until mem_ready.
//    - On the ready cycle: ir_write=1, pc_write=1, pc_src=0 -> DECODE.
//  - DECODE: register opcode internally.
//    - Legal opcode -> EXEC.
//    - Else -> FAULT with code 01.
//  - EXEC:
//    - R 0110011: alu_op=10 -> WB.
//    - I 0010011: alu_src=1, alu_op=11 -> WB.
//    - ld 0000011 / sd 0100011: alu_src=1, alu_op=00 -> MEM.
//    - beq 1100011: alu_op=01; pc_write=pc_src=zero; retire.
//  - MEM: mem_read (ld) or mem_write (sd) held until mem_ready.
//    - sd: retires on the ready cycle.
//    - ld: -> WB.
//  - WB: reg_write=1; mem_to_reg=1 for ld only; retire.
//  - Retire: instr_done=1 for one cycle; instr_cnt+1 (max wraps to 0).
//    - Next state FETCH if run=1, else IDLE.
//  - Latency at zero-wait memory: R/I/sd = 4 cycles, ld = 5, beq = 3.
//  - Timeout: in FETCH/MEM, each cycle without mem_ready increments the wait counter.
//    - Counter reaching TMO_CYC -> FAULT with code 10; request dropped the same cycle.
//    - Counter clears on state entry.
//  - FAULT: fault=1; fault_code held; all requests 0.
//    - clear_fault -> IDLE, fault/code cleared.
//    - clear_fault outside FAULT is ignored.
//  - mem_ready outside FETCH/MEM: ignored.
//  - run deassert mid-instruction: instruction completes, then IDLE.
//  - rst_n mid-access: requests drop immediately (async).
//
// STRUCTURE
//  - ctrl_pkg holds:
//    - state_t enum (IDLE, FETCH, DECODE, EXEC, MEM, WB, FAULT)
//    - opcode localparams OP_R, OP_I, OP_LD, OP_SD, OP_BEQ
//    - alu_op_t and fault_code_t encodings
//  - Sub-module mem_wait_timer (clear, tick, expired) encapsulates timeout counting.
//  - Top: state register + next-state logic + registered opcode + combinational output decode.
//
// TESTING
//  - Reset, run=1, R-type, zero-wait mem -> imem_req c1, ir_write+pc_write c1, reg_write c4,
//    instr_done c4, instr_cnt=1.
//  - ld with mem_ready delayed 3 cycles in MEM -> mem_read high 4 cycles, then WB with
//    mem_to_reg=1, total 8 cycles.
//  - beq zero=1 then zero=0 -> pc_write=pc_src=1 in EXEC first; pc_write=0 second;
//    each retires in 3 cycles.
//  - opcode 7'b1111111 -> FAULT, fault_code=01, no reg_write/mem_write ever;
//    clear_fault -> IDLE.
//  - mem_ready held 0 in FETCH -> FAULT, code 10, after exactly 15 wait cycles;
//    imem_req 0 afterwards.
//  - run dropped during MEM of sd -> store completes, instr_done pulses, then IDLE;
//    preload instr_cnt at max -> wraps to 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and opcode constants for the multi-cycle RV64-subset control sequencer.
package ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        FAULT  = 3'd6
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_RFN = 2'b10,
        ALU_IFN = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        FC_NONE    = 2'b00,
        FC_ILLEGAL = 2'b01,
        FC_TIMEOUT = 2'b10
    } fault_code_t;

    function automatic logic is_legal(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LD) ||
               (op == OP_SD) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready; flags expiry on the wait that reaches TMO_CYC.
module mem_wait_timer #(
    parameter int TMO_CYC = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic tick_i,
    output logic expired_o
);
    localparam int W = $clog2(TMO_CYC + 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cnt_q <= '0;
        else if (clear_i) cnt_q <= '0;
        else if (tick_i)  cnt_q <= cnt_q + W'(1);
    end

    // Asserted on the wait cycle whose increment lands on TMO_CYC.
    assign expired_o = tick_i && (cnt_q == W'(TMO_CYC - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer driving datapath controls and memory req/ready handshakes.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 7,
    parameter int TMO_CYC  = 15,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic                zero_i,
    input  logic                mem_ready_i,
    input  logic                clear_fault_i,
    output logic                imem_req_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic                ir_write_o,
    output logic                pc_write_o,
    output logic                pc_src_o,
    output logic                alu_src_o,
    output logic [1:0]          alu_op_o,
    output logic                mem_to_reg_o,
    output logic                reg_write_o,
    output logic                instr_done_o,
    output logic [CNT_W-1:0]    instr_cnt_o,
    output logic                fault_o,
    output logic [1:0]          fault_code_o
);
    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    fault_code_t         code_q, code_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                retire;
    logic                tmo_tick, tmo_exp, tmo_clear;

    // Wait counter restarts whenever the FSM changes state.
    assign tmo_clear = (state_d != state_q);

    mem_wait_timer #(.TMO_CYC(TMO_CYC)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (tmo_clear),
        .tick_i    (tmo_tick),
        .expired_o (tmo_exp)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        code_d       = code_q;
        retire       = 1'b0;
        tmo_tick     = 1'b0;
        imem_req_o   = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_src_o     = 1'b0;
        alu_src_o    = 1'b0;
        alu_op_o     = ALU_ADD;
        mem_to_reg_o = 1'b0;
        reg_write_o  = 1'b0;

        unique case (state_q)
            IDLE: if (run_i) state_d = FETCH;
            FETCH: begin
                imem_req_o = 1'b1;
                tmo_tick   = !mem_ready_i;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = DECODE;
                end else if (tmo_exp) begin
                    state_d = FAULT;
                    code_d  = FC_TIMEOUT;
                end
            end
            DECODE: begin
                op_d = opcode_i;
                if (is_legal(opcode_i)) begin
                    state_d = EXEC;
                end else begin
                    state_d = FAULT;
                    code_d  = FC_ILLEGAL;
                end
            end
            EXEC: begin
                case (op_q)
                    OP_R: begin
                        alu_op_o = ALU_RFN;
                        state_d  = WB;
                    end
                    OP_I: begin
                        alu_src_o = 1'b1;
                        alu_op_o  = ALU_IFN;
                        state_d   = WB;
                    end
                    OP_LD, OP_SD: begin
                        alu_src_o = 1'b1;
                        state_d   = MEM;
                    end
                    OP_BEQ: begin
                        alu_op_o   = ALU_SUB;
                        pc_write_o = zero_i;
                        pc_src_o   = zero_i;
                        retire     = 1'b1;
                    end
                    default: begin
                        state_d = FAULT;
                        code_d  = FC_ILLEGAL;
                    end
                endcase
            end
            MEM: begin
                mem_read_o  = (op_q == OP_LD);
                mem_write_o = (op_q != OP_LD);
                tmo_tick    = !mem_ready_i;
                if (mem_ready_i) begin
                    if (op_q == OP_LD) state_d = WB;
                    else               retire  = 1'b1;
                end else if (tmo_exp) begin
                    state_d = FAULT;
                    code_d  = FC_TIMEOUT;
                end
            end
            WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = (op_q == OP_LD);
                retire       = 1'b1;
            end
            FAULT: begin
                if (clear_fault_i) begin
                    state_d = IDLE;
                    code_d  = FC_NONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // run is only honoured at the instruction boundary.
        if (retire) state_d = run_i ? FETCH : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            code_q  <= FC_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            code_q  <= code_d;
            if (retire) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign instr_done_o = retire;
    assign instr_cnt_o  = cnt_q;
    assign fault_o      = (state_q == FAULT);
    assign fault_code_o = code_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed cycle-by-cycle bench for multicycle_ctrl; 3-bit retire counter exposes the wrap.
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    localparam int CW = 3;

    // Control vector layout: req rd wr irw pcw pcs asrc aop[1:0] m2r rw done
    localparam logic [11:0] C_IDLE    = 12'h000;
    localparam logic [11:0] C_FETCH   = 12'h980;
    localparam logic [11:0] C_EXEC_R  = 12'h010;
    localparam logic [11:0] C_EXEC_I  = 12'h038;
    localparam logic [11:0] C_EXEC_M  = 12'h020;
    localparam logic [11:0] C_WB      = 12'h003;
    localparam logic [11:0] C_WB_LD   = 12'h007;
    localparam logic [11:0] C_RD      = 12'h400;
    localparam logic [11:0] C_WR      = 12'h200;
    localparam logic [11:0] C_SD_DONE = 12'h201;
    localparam logic [11:0] C_BEQ_T   = 12'h0C9;
    localparam logic [11:0] C_BEQ_N   = 12'h009;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          run = 1'b0, zero = 1'b0, mem_ready = 1'b0, clear_fault = 1'b0;
    logic [6:0]    opcode = '0;
    logic          imem_req, mem_read, mem_write, ir_write, pc_write, pc_src, alu_src;
    logic [1:0]    alu_op, fault_code;
    logic          mem_to_reg, reg_write, instr_done, fault;
    logic [CW-1:0] instr_cnt;
    logic [11:0]   ctl;
    int            compared = 0, mismatched = 0;

    always #5 clk = ~clk;

    assign ctl = {imem_req, mem_read, mem_write, ir_write, pc_write, pc_src, alu_src,
                  alu_op, mem_to_reg, reg_write, instr_done};

    multicycle_ctrl #(.OPCODE_W(7), .TMO_CYC(15), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run_i         (run),
        .opcode_i      (opcode),
        .zero_i        (zero),
        .mem_ready_i   (mem_ready),
        .clear_fault_i (clear_fault),
        .imem_req_o    (imem_req),
        .mem_read_o    (mem_read),
        .mem_write_o   (mem_write),
        .ir_write_o    (ir_write),
        .pc_write_o    (pc_write),
        .pc_src_o      (pc_src),
        .alu_src_o     (alu_src),
        .alu_op_o      (alu_op),
        .mem_to_reg_o  (mem_to_reg),
        .reg_write_o   (reg_write),
        .instr_done_o  (instr_done),
        .instr_cnt_o   (instr_cnt),
        .fault_o       (fault),
        .fault_code_o  (fault_code)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Entered in a FETCH cycle; walks a zero-wait R/I instruction through retirement.
    task automatic alu_instr(input logic [6:0] op, input logic [11:0] exec_ctl,
                             input logic [CW-1:0] cnt_after);
        opcode = op; mem_ready = 1'b1;
        #1 chk("alu_fetch", 32'(ctl), 32'(C_FETCH));
        cyc(); mem_ready = 1'b0;
        #1 chk("alu_decode", 32'(ctl), 32'(C_IDLE));
        cyc();
        #1 chk("alu_exec", 32'(ctl), 32'(exec_ctl));
        cyc();
        #1 chk("alu_wb", 32'(ctl), 32'(C_WB));
        cyc();
        #1 chk("alu_cnt", 32'(instr_cnt), 32'(cnt_after));
    endtask

    initial begin
        cyc(); cyc();
        chk("rst_ctl",   32'(ctl),        32'(C_IDLE));
        chk("rst_fault", 32'(fault),      32'(0));
        chk("rst_code",  32'(fault_code), 32'(0));
        chk("rst_cnt",   32'(instr_cnt),  32'(0));
        rst_n = 1'b1;
        cyc();
        run = 1'b1;
        #1 chk("idle_ctl", 32'(ctl), 32'(C_IDLE));
        cyc();

        alu_instr(OP_R, C_EXEC_R, 3'd1);

        // ld with three extra wait cycles in MEM; stray clear_fault must be ignored
        opcode = OP_LD; mem_ready = 1'b1;
        #1 chk("ld_fetch", 32'(ctl), 32'(C_FETCH));
        cyc(); mem_ready = 1'b0; clear_fault = 1'b1;
        #1 chk("ld_decode", 32'(ctl), 32'(C_IDLE));
        cyc(); clear_fault = 1'b0;
        #1 chk("ld_exec", 32'(ctl), 32'(C_EXEC_M));
        cyc();
        for (int i = 0; i < 3; i++) begin
            #1 chk("ld_mem_wait", 32'(ctl), 32'(C_RD));
            cyc();
        end
        mem_ready = 1'b1;
        #1 chk("ld_mem_ready", 32'(ctl), 32'(C_RD));
        cyc(); mem_ready = 1'b0;
        #1 chk("ld_wb", 32'(ctl), 32'(C_WB_LD));
        cyc();
        #1 chk("ld_cnt", 32'(instr_cnt), 32'(2));
        chk("ld_nofault", 32'(fault), 32'(0));

        // beq taken then not taken
        for (int t = 1; t >= 0; t--) begin
            opcode = OP_BEQ; mem_ready = 1'b1;
            #1 chk("beq_fetch", 32'(ctl), 32'(C_FETCH));
            cyc(); mem_ready = 1'b0;
            #1 chk("beq_decode", 32'(ctl), 32'(C_IDLE));
            cyc(); zero = (t == 1);
            #1 chk("beq_exec", 32'(ctl), 32'((t == 1) ? C_BEQ_T : C_BEQ_N));
            cyc(); zero = 1'b0;
            #1 chk("beq_cnt", 32'(instr_cnt), 32'((t == 1) ? 3 : 4));
        end

        // Illegal opcode
        opcode = 7'b1111111; mem_ready = 1'b1;
        #1 chk("ill_fetch", 32'(ctl), 32'(C_FETCH));
        cyc(); mem_ready = 1'b0;
        #1 chk("ill_decode", 32'(ctl), 32'(C_IDLE));
        cyc(); mem_ready = 1'b1;
        #1 chk("ill_ctl", 32'(ctl), 32'(C_IDLE));
        chk("ill_fault", 32'(fault), 32'(1));
        chk("ill_code", 32'(fault_code), 32'(1));
        cyc(); mem_ready = 1'b0;
        #1 chk("ill_hold_ctl", 32'(ctl), 32'(C_IDLE));
        chk("ill_hold_fault", 32'(fault), 32'(1));
        clear_fault = 1'b1;
        cyc(); clear_fault = 1'b0;
        #1 chk("clr_fault", 32'(fault), 32'(0));
        chk("clr_code", 32'(fault_code), 32'(0));
        chk("clr_ctl", 32'(ctl), 32'(C_IDLE));
        chk("clr_cnt", 32'(instr_cnt), 32'(4));
        cyc();

        // Fetch timeout: 15 requesting cycles, then FAULT with code 10
        for (int i = 0; i < 15; i++) begin
            #1 chk("tmo_req", 32'(imem_req), 32'(1));
            chk("tmo_nofault", 32'(fault), 32'(0));
            cyc();
        end
        #1 chk("tmo_fault", 32'(fault), 32'(1));
        chk("tmo_code", 32'(fault_code), 32'(2));
        chk("tmo_ctl", 32'(ctl), 32'(C_IDLE));
        clear_fault = 1'b1;
        cyc(); clear_fault = 1'b0;
        #1 chk("tmo_clr", 32'(fault), 32'(0));
        cyc();

        alu_instr(OP_I, C_EXEC_I, 3'd5);
        alu_instr(OP_R, C_EXEC_R, 3'd6);
        alu_instr(OP_I, C_EXEC_I, 3'd7);

        // sd with run dropped in MEM: completes, wraps counter, parks in IDLE
        opcode = OP_SD; mem_ready = 1'b1;
        #1 chk("sd_fetch", 32'(ctl), 32'(C_FETCH));
        cyc(); mem_ready = 1'b0;
        #1 chk("sd_decode", 32'(ctl), 32'(C_IDLE));
        cyc();
        #1 chk("sd_exec", 32'(ctl), 32'(C_EXEC_M));
        cyc(); run = 1'b0;
        #1 chk("sd_mem_wait", 32'(ctl), 32'(C_WR));
        cyc(); mem_ready = 1'b1;
        #1 chk("sd_mem_done", 32'(ctl), 32'(C_SD_DONE));
        cyc(); mem_ready = 1'b0;
        #1 chk("sd_idle_ctl", 32'(ctl), 32'(C_IDLE));
        chk("sd_cnt_wrap", 32'(instr_cnt), 32'(0));
        cyc();
        #1 chk("sd_stay_idle", 32'(ctl), 32'(C_IDLE));

        // Async reset drops an in-flight fetch request immediately
        run = 1'b1;
        cyc();
        #1 chk("rst_mid_req", 32'(imem_req), 32'(1));
        rst_n = 1'b0;
        #1 chk("rst_mid_drop", 32'(imem_req), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no completion, required finish before 100000 ns");
        $fatal(1);
    end

endmodule
